// File: rtl/dsp_result_reader_if.sv
// dsp_result_reader_if
//   Bundles the DSP engine Mem2 result-write side, the frame/lock controls and
//   the EMIF-side read port of dsp_result_reader.
//   master : engine + host side (drives writes, WIP, lock, read requests)
//   slave  : dsp_result_reader (returns read data, bank index, frame status)
interface dsp_result_reader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 36,
  parameter int OUT_WIDTH  = 32
);
  logic                  Mem2_we_i;
  logic [ADDR_WIDTH-1:0] Mem2_addrw_i;
  logic [DATA_WIDTH-1:0] Mem2_data_i;
  logic                  WIP_flag_i;
  logic                  lock_i;
  logic                  rd_en_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic [OUT_WIDTH-1:0]  rd_data_o;
  logic                  rd_valid_o;
  logic                  bank_o;
  logic                  frame_done_o;
  logic [15:0]           frame_cnt_o;
  logic                  overrun_o;

  modport master (
    output Mem2_we_i, Mem2_addrw_i, Mem2_data_i, WIP_flag_i, lock_i,
           rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, bank_o, frame_done_o, frame_cnt_o, overrun_o
  );

  modport slave (
    input  Mem2_we_i, Mem2_addrw_i, Mem2_data_i, WIP_flag_i, lock_i,
           rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, bank_o, frame_done_o, frame_cnt_o, overrun_o
  );
endinterface

// File: rtl/dsp_result_reader.sv
// dsp_result_reader
//   Captures one DSP computation frame of 36-bit Mem2 results into a ping-pong
//   buffer and swaps banks when the engine drops WIP_flag_i, so EMIF reads only
//   ever see a completed frame.
//   Ports:
//     clk_i  : DSP clock, rising edge
//     rst_i  : synchronous reset, active high (RAM contents are kept)
//     bus    : dsp_result_reader_if.slave
//              write side  Mem2_we_i / Mem2_addrw_i / Mem2_data_i -> bank !bank_o
//              frame ctrl  WIP_flag_i (fall = frame done), lock_i (defers swap)
//              read side   rd_en_i / rd_addr_i -> rd_data_o / rd_valid_o, 2-cycle latency
//              status      bank_o, frame_done_o, frame_cnt_o, overrun_o (sticky)
//   Build option: READOUT_SATURATE_EN selects signed saturation to OUT_WIDTH
//   on readout instead of plain truncation.
module dsp_result_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 36,
  parameter int OUT_WIDTH  = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  dsp_result_reader_if.slave bus
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

  state_t                state;
  logic                  wip_q;
  logic                  armed_q;
  logic                  fall;
  logic                  do_swap;

  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [STAGES:0]       vld_pipe;
  logic [OUT_WIDTH-1:0]  rd_conv;

  // ---------------------------------------------------------------- frame FSM
  assign fall = wip_q & ~bus.WIP_flag_i;

  always_comb begin
    do_swap = 1'b0;
    case (state)
      RUN:     do_swap = fall & ~bus.lock_i;
      PENDING: do_swap = ~bus.lock_i;
      default: do_swap = 1'b0;
    endcase
  end

  // armed_q: a frame may only open after WIP has been seen low since reset,
  // so a frame interrupted by reset is abandoned rather than swapped in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      wip_q            <= 1'b0;
      armed_q          <= 1'b0;
      bus.bank_o       <= 1'b0;
      bus.frame_done_o <= 1'b0;
      bus.frame_cnt_o  <= '0;
      bus.overrun_o    <= 1'b0;
    end else begin
      wip_q            <= bus.WIP_flag_i;
      armed_q          <= armed_q | ~bus.WIP_flag_i;
      bus.frame_done_o <= do_swap;
      if (do_swap) begin
        bus.bank_o      <= ~bus.bank_o;
        bus.frame_cnt_o <= bus.frame_cnt_o + 16'd1;
      end
      case (state)
        IDLE: if (bus.WIP_flag_i && armed_q) state <= RUN;
        RUN: begin
          if (fall) state <= bus.lock_i ? PENDING : IDLE;
        end
        PENDING: begin
          // Leaving PENDING with WIP already high means the next frame started
          // while we waited; track it straight away.
          if (!bus.lock_i)  state <= bus.WIP_flag_i ? RUN : IDLE;
          else if (fall)    bus.overrun_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- ping-pong RAM
  // Bank is the MSB of the physical address; writes use !bank_o and reads use
  // bank_o, so the two ports never touch the same bank in one cycle.
  always_ff @(posedge clk_i) begin
    if (bus.Mem2_we_i) mem[{~bus.bank_o, bus.Mem2_addrw_i}] <= bus.Mem2_data_i;
    if (bus.rd_en_i)   rd_word_q <= mem[{bus.bank_o, bus.rd_addr_i}];
  end

  // ---------------------------------------------------------------- readout
`ifdef READOUT_SATURATE_EN
  logic [DATA_WIDTH-OUT_WIDTH:0] rd_top;
  always_comb begin
    rd_top  = rd_word_q[DATA_WIDTH-1:OUT_WIDTH-1];
    rd_conv = rd_word_q[OUT_WIDTH-1:0];
    // Upper bits not all equal -> value does not fit in OUT_WIDTH signed.
    if (!((&rd_top) || !(|rd_top)))
      rd_conv = rd_word_q[DATA_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_word_q[DATA_WIDTH-1:OUT_WIDTH];
  assign rd_conv      = rd_word_q[OUT_WIDTH-1:0];
`endif

  assign vld_pipe[0]    = bus.rd_en_i;
  assign bus.rd_valid_o = vld_pipe[STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe[STAGES:1] <= '0;
      bus.rd_data_o      <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[1]) bus.rd_data_o <= rd_conv;
    end
  end
endmodule

// File: doc/dsp_result_reader.md
Name: dsp_result_reader

Overview:
- Consumer end of the DSP engine Mem2 result-write interface (Kalman / Resonant_grid `Mem2_we`/`Mem2_addrw`/`Mem2_data` plus `WIP_flag`).
- Captures one computation frame of 36-bit results into a ping-pong buffer and swaps banks when the engine finishes.
- Serves 32-bit reads to the EMIF-side read mux from the completed bank, so the host never sees a half-updated frame.

Parameters:
- ADDR_WIDTH, 9, Mem2 word address width; depth = 2**ADDR_WIDTH per bank.
- DATA_WIDTH, 36, Mem2 data width.
- OUT_WIDTH, 32, read data width towards EMIF.

Ports:
- clk_i  input  1  DSP clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- Mem2_we_i  input  1  write strobe from the DSP engine.
- Mem2_addrw_i  input  ADDR_WIDTH  write address.
- Mem2_data_i  input  DATA_WIDTH  signed write data.
- WIP_flag_i  input  1  engine busy; falling edge = frame complete.
- lock_i  input  1  host holds the read bank; bank swaps are deferred while high.
- rd_en_i  input  1  read request, one word per cycle.
- rd_addr_i  input  ADDR_WIDTH  read address.
- rd_data_o  output  OUT_WIDTH  read data.
- rd_valid_o  output  1  qualifies rd_data_o.
- bank_o  output  1  index of the current read bank; write bank = !bank_o.
- frame_done_o  output  1  one-cycle pulse on each bank swap.
- frame_cnt_o  output  16  completed swap count, wraps at 0xFFFF -> 0.
- overrun_o  output  1  sticky: a frame was lost while a swap was pending.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - bank_o=0, frame_cnt_o=0, overrun_o=0, frame_done_o=0, rd_valid_o=0, rd_data_o=0.
  - FSM -> IDLE; WIP edge register cleared to 0.
  - RAM contents are not cleared.
  - Reset asserted mid-frame abandons the frame; no swap occurs.
- Writes:
  - Mem2_we_i=1 writes Mem2_data_i to bank !bank_o at Mem2_addrw_i in the same edge.
  - Writes are accepted in any FSM state; the write bank is sampled in the write cycle.
- WIP edge:
  - wip_q <= WIP_flag_i each cycle; fall = wip_q & !WIP_flag_i.
- FSM:
  - IDLE: WIP_flag_i=1 -> RUN.
  - RUN: on fall: if lock_i=0, swap -> IDLE; if lock_i=1 -> PENDING.
  - PENDING: when lock_i=0, swap -> IDLE (or -> RUN if WIP_flag_i=1 in that cycle).
  - PENDING: a second fall while lock_i=1 sets overrun_o and stays PENDING. The new frame overwrites the same write bank; only the latest frame is swapped in later.
  - Swap action: bank_o toggles, frame_done_o=1 for exactly one cycle, frame_cnt_o increments.
- Swap timing:
  - Swap takes effect on the clock edge after the fall is detected, i.e. fall detected in cycle N -> bank_o toggles at the end of cycle N.
  - A write in cycle N goes to the pre-swap write bank.
- Reads:
  - rd_en_i in cycle N samples bank_o and rd_addr_i in that same cycle (RAM read register).
  - Output register: rd_data_o and rd_valid_o update at edge N+2; latency is 2 cycles, fully pipelined, one read per cycle.
  - rd_valid_o=0 when no read is in flight; rd_data_o holds its last value.
  - A read issued in the swap cycle returns old-bank data.
- Read/write collision:
  - Same physical bank is impossible by construction.
  - Same address across different banks is independent.
- Width conversion (36 -> 32): see Optional Feature.
- overrun_o clears only on reset.

Optional Feature:
- Macro: READOUT_SATURATE_EN.
- Defined: rd_data_o = signed saturation of the 36-bit word to 32 bits.
  - Value > 0x7FFFFFFF -> 0x7FFFFFFF.
  - Value < -2^31 -> 0x80000000.
  - Adds no latency.
- Undefined: rd_data_o = Mem2_data[31:0] (plain truncation, wraps).

Test Plan:
- Reset, then WIP high for 20 cycles with writes addr 0..9, data = addr*3, then WIP low, lock_i=0 -> frame_done_o pulses once, bank_o=1, frame_cnt_o=1; reads of addr 0..9 return 0,3,...,27 with rd_valid_o exactly 2 cycles after each rd_en_i.
- Back-to-back reads of addr 0..9 on consecutive cycles -> 10 consecutive valid cycles, data in order, no bubbles.
- lock_i=1 across a WIP fall -> bank_o unchanged, FSM in PENDING; release lock_i -> swap one cycle later, frame_done_o=1, frame_cnt_o=1.
- lock_i=1 across two WIP falls, frame A writes 0x11 then frame B writes 0x22 at addr 5 -> overrun_o=1; after release, addr 5 reads 0x22.
- Write 36'h7_FFFF_FFFF and 36'h8_0000_0000 -> with READOUT_SATURATE_EN: 0x7FFFFFFF and 0x80000000; without: 0xFFFFFFFF and 0x00000000.
- rst_i pulsed during RUN, then WIP falls -> no swap, bank_o=0, frame_cnt_o=0, overrun_o=0, frame_done_o never asserted.
